cacheline_adaptor: RTL and testbench
====================================

CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 Parameter s_line, 256, cache line width in bits.
REQ-002 Parameter s_burst, 64, physical-memory beat width in bits.
REQ-003 Parameter n_beats, s_line/s_burst (4), beats per line transfer.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-005 clk  in  1  sole clock, all state on rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 line_i  in  s_line  line to write back, from the cache datapath's data_to_pmem.
REQ-008 line_o  out  s_line  assembled line read from memory, to the cache's data_from_pmem.
REQ-009 address_i  in  32  line address, from pmem_address_cache.
REQ-010 read_i  in  1  cache requests a line fill.
REQ-011 write_i  in  1  cache requests a line writeback.
REQ-012 resp_o  out  1  one-cycle pulse: transfer complete.
REQ-013 burst_i  in  s_burst  read beat from memory.
REQ-014 burst_o  out  s_burst  write beat to memory.
REQ-015 address_o  out  32  line-aligned memory address.
REQ-016 read_o  out  1  memory read request.
REQ-017 write_o  out  1  memory write request.
REQ-018 resp_i  in  1  memory beat strobe, one per beat.

Function
REQ-019 FSM states SHALL be IDLE, READ, WRITE, DONE.
REQ-020 In IDLE, write_i=1 SHALL move the FSM to WRITE; read_i=1 with write_i=0 SHALL move it to READ; write SHALL win when both are asserted.
REQ-021 On leaving IDLE, the block SHALL latch address_i as {address_i[31:5], 5'b0} into address_o, latch line_i for writes, and clear the 2-bit beat counter.
REQ-022 read_i and write_i SHALL be ignored outside IDLE; the latched address and line SHALL NOT change mid-transfer.
REQ-023 In READ, read_o SHALL be 1; each cycle with resp_i=1 SHALL store burst_i into line bits [64*cnt+63 : 64*cnt] and increment cnt.
REQ-024 In WRITE, write_o SHALL be 1 and burst_o SHALL equal latched-line bits [64*cnt+63 : 64*cnt]; each cycle with resp_i=1 SHALL increment cnt.
REQ-025 Beats need not be consecutive; cycles with resp_i=0 SHALL leave cnt and data unchanged.
REQ-026 The cycle accepting beat n_beats-1 SHALL transition to DONE; read_o/write_o SHALL be 0 from that edge.
REQ-027 In DONE, resp_o SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-028 line_o SHALL be fully valid while resp_o=1 and SHALL hold until the next read's first beat.
REQ-029 resp_i in IDLE or DONE SHALL be ignored.
REQ-030 Minimum latency SHALL be 1 (accept) + 4 (beats) + 1 (DONE) cycles, from request sample to resp_o.
REQ-031 A request still asserted in the IDLE cycle after DONE SHALL start a new transfer; the upstream deasserts on resp_o.

Reset
REQ-032 rst=1 SHALL immediately force IDLE, cnt=0, resp_o=0, read_o=0, write_o=0, address_o=0, burst_o=0, and line_o=0.
REQ-033 A reset mid-transfer SHALL discard partial beats without issuing resp_o; the first request after reset SHALL start from beat 0.

Verification
REQ-034 Read: address_i=0x0000_1234, read_i=1, 4 consecutive beats 0x11..,0x22..,0x33..,0x44.. -> address_o=0x0000_1220, read_o for 5 cycles, line_o={0x44..,0x33..,0x22..,0x11..}, resp_o one pulse.
REQ-035 Write: line_i=256'h0123..CDEF, write_i=1, resp_i each cycle -> burst_o shows words 0,1,2,3 in order; write_o drops after the 4th beat; one resp_o pulse.
REQ-036 Stalled beats: resp_i pattern 1,0,0,1,0,1,1 -> exactly 4 beats captured in order; resp_o one cycle after the last beat.
REQ-037 Simultaneous read_i=write_i=1 in IDLE -> write performed (write_o=1, read_o=0); line_i changed mid-burst -> burst_o still carries latched data.
REQ-038 rst asserted after beat 2 of a read -> outputs are 0 asynchronously; a subsequent read completes with 4 fresh beats and no spurious resp_o.

Source files
------------

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: bridges whole-line cache requests to a beat-wise memory burst interface.
module cacheline_adaptor #(
    parameter int s_line  = 256,
    parameter int s_burst = 64,
    parameter int n_beats = s_line / s_burst
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [s_line-1:0]   line_i,
    output logic [s_line-1:0]   line_o,
    input  logic [31:0]         address_i,
    input  logic                read_i,
    input  logic                write_i,
    output logic                resp_o,
    input  logic [s_burst-1:0]  burst_i,
    output logic [s_burst-1:0]  burst_o,
    output logic [31:0]         address_o,
    output logic                read_o,
    output logic                write_o,
    input  logic                resp_i
);
    localparam int cw = $clog2(n_beats);
    localparam int ob = $clog2(s_line / 8);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t          state, next;
    logic [cw-1:0]   cnt;
    logic [s_line-1:0] wline;
    logic            beat, last, start;

    assign beat    = resp_i && (state == READ || state == WRITE);
    assign last    = beat && cnt == cw'(n_beats - 1);
    assign start   = state == IDLE && (read_i || write_i);
    assign read_o  = state == READ;
    assign write_o = state == WRITE;
    assign resp_o  = state == DONE;
    assign burst_o = wline[s_burst*cnt +: s_burst];

    always_comb begin
        next = state;
        case (state)
            IDLE:        next = write_i ? WRITE : read_i ? READ : IDLE;
            READ, WRITE: next = last ? DONE : state;
            default:     next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            wline     <= '0;
            line_o    <= '0;
            address_o <= '0;
        end else begin
            state <= next;
            if (start) begin
                address_o <= {address_i[31:ob], {ob{1'b0}}};
                cnt       <= '0;
                if (write_i) wline <= line_i;
            end else if (beat) begin
                cnt <= cnt + 1'b1;
                // read beats land in place so line_o stays whole between fills
                if (state == READ) line_o[s_burst*cnt +: s_burst] <= burst_i;
            end
        end
    end
endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb_cacheline_adaptor: directed read/write/stall/reset scenarios with a line and beat scoreboard.
module tb_cacheline_adaptor;
    logic         clk = 0, rst = 1;
    logic [255:0] line_i = '0, line_o;
    logic [31:0]  address_i = '0, address_o;
    logic         read_i = 0, write_i = 0, resp_o, read_o, write_o, resp_i = 0;
    logic [63:0]  burst_i = '0, burst_o;

    int vectors = 0, miscompares = 0;
    logic [255:0] exp_line_q[$];
    logic [63:0]  exp_beat_q[$];
    logic [31:0]  exp_addr_q[$];

    cacheline_adaptor dut (
        .clk(clk), .rst(rst), .line_i(line_i), .line_o(line_o), .address_i(address_i),
        .read_i(read_i), .write_i(write_i), .resp_o(resp_o), .burst_i(burst_i),
        .burst_o(burst_o), .address_o(address_o), .read_o(read_o), .write_o(write_o),
        .resp_i(resp_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // wr: write transfer; both: also raise read_i; pat: resp_i per cycle (1 past plen)
    task automatic xfer(input bit wr, input bit both, input logic [31:0] a, input logic [255:0] line,
                        input logic [15:0] pat, input int plen, input int exp_cyc);
        int  cyc = 0, bi = 0;
        bit  done = 0, r;
        logic [255:0] got;
        @(negedge clk);
        address_i = a;
        read_i    = !wr || both;
        write_i   = wr;
        exp_addr_q.push_back({a[31:5], 5'b0});
        if (wr) begin
            line_i = line;
            for (int i = 0; i < 4; i++) exp_beat_q.push_back(line[64*i +: 64]);
        end else exp_line_q.push_back(line);
        @(negedge clk);
        while (!done && cyc < 60) begin
            if (resp_o) done = 1;
            else begin
                chk(wr ? "write_o_active" : "read_o_active", {read_o, write_o}, wr ? 2'b01 : 2'b10);
                r = bi < 4 && (cyc < plen ? pat[cyc] : 1'b1);
                if (wr && r) chk("burst_o", burst_o, exp_beat_q.pop_front());
                if (wr && cyc == 0) line_i = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                burst_i = (!wr && r) ? line[64*bi +: 64] : 64'hdead_beef_dead_beef;
                resp_i  = r;
                if (r) bi++;
                cyc++;
                @(negedge clk);
            end
        end
        chk("resp_o_seen", done, 1'b1);
        resp_i = 0; read_i = 0; write_i = 0;
        chk("active_cycles", cyc, exp_cyc);
        chk("address_o", address_o, exp_addr_q.pop_front());
        chk("req_low_in_done", {read_o, write_o}, 2'b00);
        if (!wr) begin
            got = exp_line_q.pop_front();
            chk("line_o", line_o, got);
        end
        @(negedge clk);
        chk("resp_o_one_pulse", resp_o, 1'b0);
    endtask

    logic [255:0] rd_line, wr_line, rd2_line;

    initial begin
        rd_line  = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                    64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        wr_line  = 256'h0123456789abcdef_fedcba9876543210_0011223344556677_8899aabbccddeeff;
        rd2_line = 256'haaaa0000bbbb1111_cccc2222dddd3333_eeee4444ffff5555_0606060607070707;
        #3;
        chk("reset_outputs", {resp_o, read_o, write_o, address_o, burst_o}, '0);
        chk("reset_line_o", line_o, '0);
        @(negedge clk); rst = 0;

        // basic read: one memory latency bubble then four beats
        xfer(0, 0, 32'h0000_1234, rd_line, 16'b11110, 5, 5);
        // writeback of every word in order, line_i scrambled mid-burst
        xfer(1, 0, 32'h0000_8000, wr_line, 16'b1111, 4, 4);
        chk("line_o_held", line_o, rd_line);
        // stalled beats 1,0,0,1,0,1,1
        xfer(0, 0, 32'hffff_ffff, rd2_line, 16'b1101001, 7, 7);
        // simultaneous read and write: write wins
        xfer(1, 1, 32'h1234_567f, ~wr_line, 16'b1011, 4, 5);

        // reset after two beats of a read
        @(negedge clk);
        address_i = 32'h0000_4000; read_i = 1;
        @(negedge clk); resp_i = 1; burst_i = 64'h5555_5555_5555_5555;
        @(negedge clk); burst_i = 64'h6666_6666_6666_6666;
        @(negedge clk); resp_i = 0;
        #2 rst = 1;
        #1;
        chk("async_reset_ctrl", {resp_o, read_o, write_o}, 3'b000);
        chk("async_reset_addr", address_o, '0);
        chk("async_reset_burst", burst_o, '0);
        chk("async_reset_line", line_o, '0);
        @(negedge clk); rst = 0; read_i = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_spurious_resp", {resp_o, read_o, write_o}, 3'b000);
        end
        xfer(0, 0, 32'h0000_4010, rd_line ^ rd2_line, 16'b1111, 4, 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
